// File: rtl/add_share_arbiter_if.sv
// add_share_arbiter_if: request/response bundle for the shared adder.
//   master : requester/consumer side (drives req_*, rsp_ready)
//   slave  : arbiter side (drives req_ready, rsp_*)
//   req_valid/req_ready : per-requester handshake, bit i = requester i
//   req_opN, req_aN, req_bN : requester N operation (0=ADD, 1=SUB) and operands
//   rsp_valid/rsp_ready : shared response handshake
//   rsp_id, rsp_result, rsp_zf/sf/of : response owner, result and condition codes
interface add_share_arbiter_if #(
    parameter int W = 64
);
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic         req_op0;
    logic [W-1:0] req_a0;
    logic [W-1:0] req_b0;
    logic         req_op1;
    logic [W-1:0] req_a1;
    logic [W-1:0] req_b1;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_zf;
    logic         rsp_sf;
    logic         rsp_of;

    modport master (
        output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_of
    );

    modport slave (
        input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_of
    );
endinterface

// File: rtl/add_share_arbiter.sv
// add_share_arbiter: two requesters share a single 64-bit adder.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : add_share_arbiter_if slave port (request/response handshakes)
//   busy  : high whenever the FSM is not IDLE
// ADD takes one adder pass (EXEC); SUB first negates b (NEG), then adds.
// Round-robin on ties, Y86 ZF/SF/OF produced with every result.

module add_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum
);
    assign sum = a + b;
endmodule

module add_share_arbiter #(
    parameter int W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    add_share_arbiter_if.slave   bus,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, NEG, EXEC, RESP} state_t;

    state_t       state_reg, state_next;
    logic         last_grant_reg;
    logic         op_reg;
    logic         id_reg;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [W-1:0] b_eff_reg;
    logic         rsp_id_reg;
    logic [W-1:0] rsp_result_reg;
    logic         rsp_zf_reg;
    logic         rsp_sf_reg;
    logic         rsp_of_reg;

    logic [1:0]   grant;
    logic         accept;
    logic         sel;
    logic         sel_op;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W-1:0] sum;
    logic         ovf;

    // Grant only from IDLE; ready is also held low while reset is asserted so
    // nothing can look granted on an edge that is going to be a reset edge.
    always_comb begin
        grant = 2'b00;
        if (rst_n && state_reg == IDLE) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign accept        = |grant;
    assign sel           = grant[1];
    assign sel_op        = sel ? bus.req_op1 : bus.req_op0;
    assign sel_a         = sel ? bus.req_a1  : bus.req_a0;
    assign sel_b         = sel ? bus.req_b1  : bus.req_b0;

    // Single adder: NEG forms ~b + 1, otherwise a + b_eff.
    always_comb begin
        add_a = a_reg;
        add_b = b_eff_reg;
        if (state_reg == NEG) begin
            add_a = ~b_reg;
            add_b = W'(1);
        end
    end

    add_64bit u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (sum)
    );

    // Overflow uses the original b so SUB with b = -2^63 is still reported
    // correctly even though negating it wraps back to -2^63.
    always_comb begin
        if (op_reg)
            ovf = (a_reg[W-1] != b_reg[W-1]) && (sum[W-1] != a_reg[W-1]);
        else
            ovf = (a_reg[W-1] == b_reg[W-1]) && (sum[W-1] != a_reg[W-1]);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = sel_op ? NEG : EXEC;
            NEG:  state_next = EXEC;
            EXEC: state_next = RESP;
            RESP: if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            op_reg         <= 1'b0;
            id_reg         <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            b_eff_reg      <= '0;
            rsp_id_reg     <= 1'b0;
            rsp_result_reg <= '0;
            rsp_zf_reg     <= 1'b0;
            rsp_sf_reg     <= 1'b0;
            rsp_of_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg         <= sel_op;
                        id_reg         <= sel;
                        a_reg          <= sel_a;
                        b_reg          <= sel_b;
                        b_eff_reg      <= sel_b;
                        last_grant_reg <= sel;
                    end
                end
                NEG: b_eff_reg <= sum;
                EXEC: begin
                    rsp_id_reg     <= id_reg;
                    rsp_result_reg <= sum;
                    rsp_zf_reg     <= (sum == '0);
                    rsp_sf_reg     <= sum[W-1];
                    rsp_of_reg     <= ovf;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid  = (state_reg == RESP);
    assign bus.rsp_id     = rsp_id_reg;
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_zf     = rsp_zf_reg;
    assign bus.rsp_sf     = rsp_sf_reg;
    assign bus.rsp_of     = rsp_of_reg;
    assign busy           = (state_reg != IDLE);
endmodule

// File: tb/tb_add_share_arbiter.sv
// tb_add_share_arbiter: scoreboard bench for add_share_arbiter.
module tb_add_share_arbiter;
    typedef struct packed {
        logic        id;
        logic [63:0] res;
        logic        zf;
        logic        sf;
        logic        of;
        logic [1:0]  lat;
    } exp_t;

    logic clk;
    logic rst_n;
    logic busy;

    add_share_arbiter_if #(.W(64)) bus ();

    add_share_arbiter #(.W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_rsp = 0;
    exp_t sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference result from 65-bit arithmetic: overflow when the wide result
    // does not fit in 64 signed bits.
    function automatic exp_t model(input logic id, input logic op,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic signed [64:0] wide;
        if (op) wide = $signed({a[63], a}) - $signed({b[63], b});
        else    wide = $signed({a[63], a}) + $signed({b[63], b});
        e.id  = id;
        e.res = wide[63:0];
        e.zf  = (wide[63:0] == 64'd0);
        e.sf  = wide[63];
        e.of  = (wide[64] != wide[63]);
        e.lat = op ? 2'd3 : 2'd2;
        return e;
    endfunction

    // Monitor: per-cycle checks against a small protocol model.
    logic       m_busy = 1'b0;
    logic       m_last = 1'b1;
    int         acc_cyc = 0;
    logic       rst_prev_low = 1'b0;

    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        logic       exp_val;
        exp_t       e;
        if (!rst_n) begin
            if (rst_prev_low) begin
                chk("rst_ready",  64'(bus.req_ready), 64'd0);
                chk("rst_valid",  64'(bus.rsp_valid), 64'd0);
                chk("rst_busy",   64'(busy), 64'd0);
                chk("rst_id",     64'(bus.rsp_id), 64'd0);
                chk("rst_result", bus.rsp_result, 64'd0);
                chk("rst_flags",  64'({bus.rsp_zf, bus.rsp_sf, bus.rsp_of}), 64'd0);
            end
            rst_prev_low = 1'b1;
            m_busy = 1'b0;
            m_last = 1'b1;
            sb_q.delete();
        end else begin
            rst_prev_low = 1'b0;
            exp_rdy = 2'b00;
            if (!m_busy) begin
                case (bus.req_valid)
                    2'b01:   exp_rdy = 2'b01;
                    2'b10:   exp_rdy = 2'b10;
                    2'b11:   exp_rdy = m_last ? 2'b01 : 2'b10;
                    default: exp_rdy = 2'b00;
                endcase
            end
            chk("ready", 64'(bus.req_ready), 64'(exp_rdy));
            chk("busy", 64'(busy), 64'(m_busy));
            exp_val = 1'b0;
            if (m_busy && sb_q.size() > 0)
                exp_val = (cyc - acc_cyc + 1) >= int'(sb_q[0].lat);
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_val));
            if (bus.rsp_valid && exp_val) begin
                e = sb_q[0];
                chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                chk("rsp_result", bus.rsp_result, e.res);
                chk("rsp_zf", 64'(bus.rsp_zf), 64'(e.zf));
                chk("rsp_sf", 64'(bus.rsp_sf), 64'(e.sf));
                chk("rsp_of", 64'(bus.rsp_of), 64'(e.of));
                if (bus.rsp_ready) begin
                    $display("rsp id=%0d result=%0h zf=%0d sf=%0d of=%0d", bus.rsp_id,
                             bus.rsp_result, bus.rsp_zf, bus.rsp_sf, bus.rsp_of);
                    void'(sb_q.pop_front());
                    m_busy = 1'b0;
                    n_rsp++;
                end
            end
            if (exp_rdy != 2'b00) begin
                if (exp_rdy[1]) e = model(1'b1, bus.req_op1, bus.req_a1, bus.req_b1);
                else            e = model(1'b0, bus.req_op0, bus.req_a0, bus.req_b0);
                sb_q.push_back(e);
                m_busy  = 1'b1;
                m_last  = exp_rdy[1];
                acc_cyc = cyc + 1;
            end
        end
    end

    task automatic set_req(input logic id, input logic op, input logic [63:0] a,
                           input logic [63:0] b);
        if (id) begin
            bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
        end else begin
            bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
        end
    endtask

    // Present a request and hold it until accepted; returns 1 time unit
    // after the accept edge.
    task automatic issue(input logic id, input logic op, input logic [63:0] a,
                         input logic [63:0] b);
        @(posedge clk); #1;
        set_req(id, op, a, b);
        bus.req_valid[id] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready[id]) begin
                @(posedge clk); #1;
                bus.req_valid[id] = 1'b0;
                return;
            end
        end
        chk("issue_timeout", 64'd1, 64'd0);
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0) return;
        end
        chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) return;
        end
        chk("busy_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_rsp(input int n);
        int target;
        target = n_rsp + n;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (n_rsp >= target) return;
        end
        chk("rsp_timeout", 64'(n_rsp), 64'(target));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        set_req(1'b0, 1'b0, 64'd0, 64'd0);
        set_req(1'b1, 1'b0, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases.
        issue(1'b0, 1'b0, 64'd39, 64'd9033830);
        wait_idle();
        issue(1'b1, 1'b1, 64'd5, 64'd5);
        wait_idle();
        issue(1'b0, 1'b1, 64'd0, 64'h8000_0000_0000_0000);
        wait_idle();
        issue(1'b1, 1'b0, 64'h7fff_ffff_ffff_ffff, 64'd1);
        wait_idle();
        issue(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd1);
        wait_idle();
        issue(1'b1, 1'b0, 64'hffff_ffff_ffff_ffff, 64'd1);
        wait_idle();

        // Random operations.
        for (int i = 0; i < 8; i++) begin
            issue(1'(i % 2), 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
            wait_idle();
        end

        // Round-robin with both requesters valid.
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 64'd100, -64'sd7);
        set_req(1'b1, 1'b1, -64'sd50, 64'd1000);
        bus.req_valid = 2'b11;
        wait_rsp(6);
        wait_busy();
        @(posedge clk); #1 bus.req_valid = 2'b00;
        wait_idle();

        // Backpressure: response held for 5 cycles, no new grant meanwhile.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 1'b0, 64'd12345, 64'd678);
        set_req(1'b1, 1'b1, 64'd1, 64'd2);
        bus.req_valid = 2'b11;
        for (int i = 0; i < 50 && !bus.rsp_valid; i++) @(negedge clk);
        chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        wait_rsp(2);
        wait_busy();
        @(posedge clk); #1 bus.req_valid = 2'b00;
        wait_idle();

        // Reset during NEG of a SUB, then a tie must go to requester 0.
        issue(1'b1, 1'b1, 64'd77, 64'd22);
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 64'd3, 64'd4);
        set_req(1'b1, 1'b0, 64'd10, 64'd20);
        bus.req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tie_grant", 64'(bus.req_ready), 64'd1);
        wait_rsp(2);
        wait_busy();
        @(posedge clk); #1 bus.req_valid = 2'b00;
        wait_idle();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
